mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 15 +
 rtl/mem_responder_mem_array.sv | 22 ++
 rtl/mem_responder.sv | 105 ++++++++++
 tb/tb_mem_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and defaults for the mem_responder block: FSM states,
// default geometry/latency and the latency counter width.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEFAULT_DEPTH   = 64;
  localparam int DEFAULT_LATENCY = 2;
  localparam int CNT_W           = 4;

endpackage

// File: rtl/mem_responder_mem_array.sv
// Word-indexed storage: synchronous write, combinational read.
// Intentionally unreset so contents survive a block reset.
module mem_array #(
  parameter int DEPTH = 64,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts one request, waits LATENCY
// cycles, performs the access, then holds the response until it is taken.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; the responder keeps rsp_valid/rsp_rdata/rsp_err stable until then,
// and only raises req_ready while no transaction is outstanding.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output state_t      fsm_state
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic               we_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic               access;
  logic               err;
  logic               mem_we;
  logic [IDX_W-1:0]   idx;
  logic [31:0]        mem_rdata;

  // High address bits take part in the range check so large addresses never alias.
  assign idx    = addr_q[IDX_W+1:2];
  assign err    = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= 32'(DEPTH));
  assign access = (state == BUSY) && (cnt == '0);
  assign mem_we = access && we_q && !err;

  assign fsm_state = state;

  mem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .idx   (idx),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = BUSY;
      end
      BUSY: begin
        if (cnt == '0) state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && req_valid) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        cnt     <= CNT_W'(LATENCY - 1);
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (access) begin
        rsp_err   <= err;
        rsp_rdata <= (!we_q && !err) ? mem_rdata : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (LATENCY 2, 3 and 1) driven with
// directed requests; responses are checked against an expected queue.
module tb_mem_responder;
  import mem_responder_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // u2: default LATENCY=2
  logic r2_valid, r2_ready, r2_we, s2_valid, s2_ready, s2_err;
  logic [31:0] r2_addr, r2_wdata, s2_rdata;
  state_t st2;
  // u3: LATENCY=3
  logic r3_valid, r3_ready, r3_we, s3_valid, s3_ready, s3_err;
  logic [31:0] r3_addr, r3_wdata, s3_rdata;
  state_t st3;
  // u1: LATENCY=1
  logic r1_valid, r1_ready, r1_we, s1_valid, s1_ready, s1_err;
  logic [31:0] r1_addr, r1_wdata, s1_rdata;
  state_t st1;

  logic [32:0] exp_q2[$];
  logic [32:0] exp_q3[$];
  logic [32:0] exp_q1[$];

  mem_responder u2 (
    .clk(clk), .reset(reset), .req_valid(r2_valid), .req_ready(r2_ready),
    .req_we(r2_we), .req_addr(r2_addr), .req_wdata(r2_wdata),
    .rsp_valid(s2_valid), .rsp_ready(s2_ready), .rsp_rdata(s2_rdata),
    .rsp_err(s2_err), .fsm_state(st2)
  );

  mem_responder #(.DEPTH(64), .LATENCY(3)) u3 (
    .clk(clk), .reset(reset), .req_valid(r3_valid), .req_ready(r3_ready),
    .req_we(r3_we), .req_addr(r3_addr), .req_wdata(r3_wdata),
    .rsp_valid(s3_valid), .rsp_ready(s3_ready), .rsp_rdata(s3_rdata),
    .rsp_err(s3_err), .fsm_state(st3)
  );

  mem_responder #(.DEPTH(64), .LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .req_valid(r1_valid), .req_ready(r1_ready),
    .req_we(r1_we), .req_addr(r1_addr), .req_wdata(r1_wdata),
    .rsp_valid(s1_valid), .rsp_ready(s1_ready), .rsp_rdata(s1_rdata),
    .rsp_err(s1_err), .fsm_state(st1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: pop and compare whenever a response handshake is seen.
  always @(negedge clk) begin
    if (s2_valid === 1'b1 && s2_ready === 1'b1) begin
      if (exp_q2.size() == 0) check("u2_unexpected_rsp", 64'(s2_valid), 64'd0);
      else check("u2_rsp", 64'({s2_err, s2_rdata}), 64'(exp_q2.pop_front()));
    end
    if (s3_valid === 1'b1 && s3_ready === 1'b1) begin
      if (exp_q3.size() == 0) check("u3_unexpected_rsp", 64'(s3_valid), 64'd0);
      else check("u3_rsp", 64'({s3_err, s3_rdata}), 64'(exp_q3.pop_front()));
    end
    if (s1_valid === 1'b1 && s1_ready === 1'b1) begin
      if (exp_q1.size() == 0) check("u1_unexpected_rsp", 64'(s1_valid), 64'd0);
      else check("u1_rsp", 64'({s1_err, s1_rdata}), 64'(exp_q1.pop_front()));
    end
  end

  task automatic req2(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic err, input logic [31:0] rdata, input int hold);
    int lat;
    logic [32:0] snap;
    s2_ready = (hold == 0);
    @(negedge clk);
    for (int i = 0; i < 20 && !r2_ready; i++) @(negedge clk);
    check("u2_req_ready", 64'(r2_ready), 64'd1);
    r2_valid = 1'b1; r2_we = we; r2_addr = addr; r2_wdata = wdata;
    exp_q2.push_back({err, rdata});
    @(posedge clk); #1;
    // Junk on the request bus while busy must have no effect.
    r2_valid = 1'b0; r2_we = ~we; r2_addr = 32'h0000_0064; r2_wdata = 32'hFFFF_FFFF;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!s2_valid && lat < 20);
    check("u2_latency", 64'(lat), 64'd2);
    if (hold > 0) begin
      snap = {s2_err, s2_rdata};
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        check("u2_hold_valid", 64'(s2_valid), 64'd1);
        check("u2_hold_data", 64'({s2_err, s2_rdata}), 64'(snap));
        check("u2_hold_req_ready", 64'(r2_ready), 64'd0);
      end
      s2_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("u2_rsp_drop", 64'(s2_valid), 64'd0);
  endtask

  task automatic req3(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic err, input logic [31:0] rdata);
    int lat;
    @(negedge clk);
    for (int i = 0; i < 20 && !r3_ready; i++) @(negedge clk);
    check("u3_req_ready", 64'(r3_ready), 64'd1);
    r3_valid = 1'b1; r3_we = we; r3_addr = addr; r3_wdata = wdata;
    exp_q3.push_back({err, rdata});
    @(posedge clk); #1;
    r3_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!s3_valid && lat < 20);
    check("u3_latency", 64'(lat), 64'd3);
    @(posedge clk); #1;
  endtask

  // Back-to-back table for u1: stores, loads, then error cases.
  logic        b_we    [6];
  logic [31:0] b_addr  [6];
  logic [31:0] b_wdata [6];
  logic        b_err   [6];
  logic [31:0] b_rdata [6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc, n_hs, last_rsp, nxt;
    reset = 1'b1;
    r2_valid = 0; r2_we = 0; r2_addr = 0; r2_wdata = 0; s2_ready = 1;
    r3_valid = 0; r3_we = 0; r3_addr = 0; r3_wdata = 0; s3_ready = 1;
    r1_valid = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0; s1_ready = 1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_req_ready", 64'({r1_ready, r2_ready, r3_ready}), 64'h7);
    check("reset_rsp_valid", 64'({s1_valid, s2_valid, s3_valid}), 64'h0);
    check("reset_rsp_err", 64'({s1_err, s2_err, s3_err}), 64'h0);
    check("reset_rsp_rdata", 64'(s2_rdata | s3_rdata | s1_rdata), 64'h0);
    check("reset_state", 64'(st2), 64'(IDLE));

    // LATENCY=2 directed sequence
    req2(1'b1, 32'h0000_0064, 32'd7,          1'b0, 32'h0,        0);
    req2(1'b0, 32'h0000_0064, 32'h0,          1'b0, 32'd7,        0);
    req2(1'b0, 32'h0000_0062, 32'h0,          1'b1, 32'h0,        0);
    req2(1'b1, 32'h0000_0000, 32'h0000_0011,  1'b0, 32'h0,        0);
    req2(1'b1, 32'h0000_0100, 32'h0000_0BAD,  1'b1, 32'h0,        0);
    req2(1'b0, 32'h0000_0000, 32'h0,          1'b0, 32'h0000_0011, 0);
    req2(1'b1, 32'h8000_0064, 32'h0000_0055,  1'b1, 32'h0,        0);
    req2(1'b0, 32'h0000_0064, 32'h0,          1'b0, 32'd7,        0);
    req2(1'b1, 32'h0000_00FC, 32'h0000_A5A5,  1'b0, 32'h0,        0);
    req2(1'b0, 32'h0000_00FC, 32'h0,          1'b0, 32'h0000_A5A5, 3);
    req2(1'b1, 32'h0000_00FD, 32'h1234_0000,  1'b1, 32'h0,        0);
    req2(1'b0, 32'h0000_00FC, 32'h0,          1'b0, 32'h0000_A5A5, 0);

    // LATENCY=3: reset while a store is still pending
    req3(1'b1, 32'h0000_0060, 32'h1234_5678, 1'b0, 32'h0);
    @(negedge clk);
    r3_valid = 1'b1; r3_we = 1'b1; r3_addr = 32'h0000_0060; r3_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    r3_valid = 1'b0;
    @(posedge clk); #1;
    check("u3_busy_before_reset", 64'(st3), 64'(BUSY));
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("u3_post_reset_valid", 64'(s3_valid), 64'd0);
    check("u3_post_reset_ready", 64'(r3_ready), 64'd1);
    repeat (3) @(negedge clk);
    check("u3_no_stale_rsp", 64'(s3_valid), 64'd0);
    req3(1'b0, 32'h0000_0060, 32'h0, 1'b0, 32'h1234_5678);

    // LATENCY=1: back-to-back with req_valid held high
    b_we[0] = 1; b_addr[0] = 32'h00; b_wdata[0] = 32'hCAFE_0001; b_err[0] = 0; b_rdata[0] = 32'h0;
    b_we[1] = 1; b_addr[1] = 32'h04; b_wdata[1] = 32'hCAFE_0002; b_err[1] = 0; b_rdata[1] = 32'h0;
    b_we[2] = 0; b_addr[2] = 32'h00; b_wdata[2] = 32'h0;         b_err[2] = 0; b_rdata[2] = 32'hCAFE_0001;
    b_we[3] = 0; b_addr[3] = 32'h04; b_wdata[3] = 32'h0;         b_err[3] = 0; b_rdata[3] = 32'hCAFE_0002;
    b_we[4] = 0; b_addr[4] = 32'h62; b_wdata[4] = 32'h0;         b_err[4] = 1; b_rdata[4] = 32'h0;
    b_we[5] = 1; b_addr[5] = 32'h100; b_wdata[5] = 32'h5;        b_err[5] = 1; b_rdata[5] = 32'h0;
    n_acc = 0; n_hs = 0; last_rsp = -1; nxt = 0;
    @(negedge clk);
    r1_valid = 1'b1; r1_we = b_we[0]; r1_addr = b_addr[0]; r1_wdata = b_wdata[0];
    for (int c = 0; c < 60 && n_hs < 6; c++) begin
      if (c > 0) @(negedge clk);
      check("u1_no_overlap", 64'(r1_ready & s1_valid), 64'd0);
      if (s1_valid) begin
        n_hs++;
        if (last_rsp >= 0) check("u1_rsp_period", 64'(c - last_rsp), 64'd3);
        last_rsp = c;
      end
      nxt = 0;
      if (r1_valid && r1_ready) begin
        exp_q1.push_back({b_err[n_acc], b_rdata[n_acc]});
        n_acc++;
        nxt = 1;
      end
      @(posedge clk); #1;
      if (nxt == 1) begin
        if (n_acc < 6) begin
          r1_we = b_we[n_acc]; r1_addr = b_addr[n_acc]; r1_wdata = b_wdata[n_acc];
        end else begin
          r1_valid = 1'b0;
        end
      end
    end
    check("u1_accepts", 64'(n_acc), 64'd6);
    check("u1_handshakes", 64'(n_hs), 64'd6);

    repeat (3) @(negedge clk);
    check("u2_queue_empty", 64'(exp_q2.size()), 64'd0);
    check("u3_queue_empty", 64'(exp_q3.size()), 64'd0);
    check("u1_queue_empty", 64'(exp_q1.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
